// File: rtl/hazard_unit_if.sv
// Control bundle between the pipeline and hazard_unit: hazard inputs, stall/flush controls,
// the writeback shadow for forwarding_unit and the optional performance counters.
interface hazard_unit_if;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_rd_addr;
  logic        ex_mem_read;
  logic        ex_redirect;
  logic        mdu_busy;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_write;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic [4:0]  temp_rd_addr;
  logic        temp_reg_write;
  logic [1:0]  hazard_state;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  // Pipeline side: supplies hazard sources, consumes the controls.
  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rd_addr, ex_mem_read, ex_redirect, mdu_busy,
           wb_rd_addr, wb_reg_write,
    input  pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
           ex_mem_flush, temp_rd_addr, temp_reg_write, hazard_state,
           stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rd_addr, ex_mem_read, ex_redirect, mdu_busy,
           wb_rd_addr, wb_reg_write,
    output pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
           ex_mem_flush, temp_rd_addr, temp_reg_write, hazard_state,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage RV32 pipeline plus the WB shadow used by forwarding_unit.
// Defining HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush-event counters.
module hazard_unit #(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned FLUSH_CYCLES   = 1
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MDU_WAIT   = 2'b10,
    FLUSH      = 2'b11
  } state_t;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_STALL - 1);
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state, state_next;
  logic [2:0] stall_cnt, stall_cnt_next;
  logic [1:0] flush_cnt, flush_cnt_next;
  logic       lu;
  logic       use_run_eval;
  logic       pc_stall, if_id_stall, id_ex_stall;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;
  logic [4:0] temp_rd_addr;
  logic       temp_reg_write;

  assign lu = hz.ex_mem_read && (hz.ex_rd_addr != 5'd0) &&
              ((hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
               (hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // MDU_WAIT behaves like RUN; LOAD_STALL/FLUSH fall back to it only when preempted.
  always_comb begin
    state_next     = state;
    stall_cnt_next = stall_cnt;
    flush_cnt_next = flush_cnt;
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    id_ex_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    use_run_eval   = 1'b0;

    case (state)
      LOAD_STALL: begin
        if (hz.mdu_busy || hz.ex_redirect) begin
          use_run_eval = 1'b1;
        end else begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (stall_cnt <= 3'd1) begin
            state_next     = RUN;
            stall_cnt_next = '0;
          end else begin
            stall_cnt_next = stall_cnt - 3'd1;
          end
        end
      end
      FLUSH: begin
        if (hz.mdu_busy || hz.ex_redirect) begin
          use_run_eval = 1'b1;
        end else begin
          if_id_flush = 1'b1;
          if (flush_cnt <= 2'd1) begin
            state_next     = RUN;
            flush_cnt_next = '0;
          end else begin
            flush_cnt_next = flush_cnt - 2'd1;
          end
        end
      end
      default: use_run_eval = 1'b1;
    endcase

    if (use_run_eval) begin
      state_next     = RUN;
      stall_cnt_next = '0;
      flush_cnt_next = '0;
      if (hz.mdu_busy) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
        state_next   = MDU_WAIT;
      end else if (hz.ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_RELOAD;
        end
      end else if (lu) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        if (LOAD_USE_STALL > 1) begin
          state_next     = LOAD_STALL;
          stall_cnt_next = STALL_RELOAD;
        end
      end
    end
  end

  // Shadow runs every cycle regardless of stalls; x0 writes never become valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      temp_rd_addr   <= '0;
      temp_reg_write <= 1'b0;
    end else begin
      temp_rd_addr   <= hz.wb_rd_addr;
      temp_reg_write <= hz.wb_reg_write && (hz.wb_rd_addr != 5'd0);
    end
  end

  assign hz.pc_stall       = pc_stall;
  assign hz.if_id_stall    = if_id_stall;
  assign hz.id_ex_stall    = id_ex_stall;
  assign hz.if_id_flush    = if_id_flush;
  assign hz.id_ex_flush    = id_ex_flush;
  assign hz.ex_mem_flush   = ex_mem_flush;
  assign hz.temp_rd_addr   = temp_rd_addr;
  assign hz.temp_reg_write = temp_reg_write;
  assign hz.hazard_state   = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;
  logic        if_id_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      if_id_flush_q  <= 1'b0;
    end else begin
      if_id_flush_q <= if_id_flush;
      if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (if_id_flush && !if_id_flush_q && (flush_events_q != 32'hFFFF_FFFF)) begin
        flush_events_q <= flush_events_q + 32'd1;
      end
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_events = '0;
`endif

endmodule
